// File: rtl/memory_responder_pkg.sv
// Shared encodings for the memory responder: FSM state codes and the
// memory_command encoding used by the controller.
package memory_responder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t WAIT    = 2'd1;
    localparam state_t ACCESS  = 2'd2;
    localparam state_t RESPOND = 2'd3;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/memory_responder_wait_state_counter.sv
// Loadable down-counter that paces the wait-state phase; zero is asserted
// when the count is exhausted.
module wait_state_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             decrement,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (decrement && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/memory_responder.sv
// Slave side of the core memory handshake: latches a request, optionally waits,
// performs one access on a synchronous SRAM and returns a one-cycle valid.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 14,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  memory_enable,
    input  logic                  memory_command,
    input  logic [31:0]           address,
    input  logic [31:0]           write_data,
    input  logic [3:0]            write_strobe,
    output logic                  memory_ready,
    output logic                  memory_valid,
    output logic [31:0]           read_data,
    output logic                  bus_error,
    output logic                  sram_en,
    output logic [3:0]            sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    state_t                state_q, state_d;
    logic                  ready_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  cmd_q;
    logic                  err_q;
    logic [31:0]           wdata_q;
    logic [3:0]            strb_q;
    logic [31:0]           rdata_hold_q;
    logic                  accept;
    logic                  out_of_range;
    logic                  wait_zero;

    assign accept       = ready_q && memory_enable;
    assign out_of_range = (address >> (ADDR_WIDTH + 2)) != 32'd0;

    if (WAIT_STATES > 0) begin : g_wait
        localparam logic [3:0] WaitLoad = 4'(WAIT_STATES - 1);

        wait_state_counter #(
            .WIDTH(4)
        ) u_wait_counter (
            .clk       (clk),
            .reset_n   (reset_n),
            .load      (accept && !out_of_range),
            .load_value(WaitLoad),
            .decrement (state_q == WAIT),
            .zero      (wait_zero)
        );
    end else begin : g_no_wait
        assign wait_zero = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (out_of_range)          state_d = RESPOND;
                    else if (WAIT_STATES == 0) state_d = ACCESS;
                    else                       state_d = WAIT;
                end
            end
            WAIT:    if (wait_zero) state_d = ACCESS;
            ACCESS:  state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            addr_q       <= '0;
            cmd_q        <= MEM_READ;
            err_q        <= 1'b0;
            wdata_q      <= '0;
            strb_q       <= '0;
            rdata_hold_q <= '0;
        end else begin
            state_q <= state_d;
            // Ready is a flop so it can never coincide with the valid pulse.
            ready_q <= (state_d == IDLE);
            if (accept) begin
                addr_q  <= address[ADDR_WIDTH+1:2];
                cmd_q   <= memory_command;
                err_q   <= out_of_range;
                wdata_q <= write_data;
                strb_q  <= write_strobe;
            end
            if (state_q == RESPOND) rdata_hold_q <= read_data;
        end
    end

    always_comb begin
        memory_ready = ready_q;
        memory_valid = (state_q == RESPOND);
        bus_error    = memory_valid && err_q;
        read_data    = rdata_hold_q;
        if (memory_valid) begin
            read_data = (err_q || (cmd_q == MEM_WRITE)) ? 32'd0 : sram_rdata;
        end
        sram_en    = (state_q == ACCESS);
        sram_we    = (sram_en && (cmd_q == MEM_WRITE)) ? strb_q : 4'b0000;
        sram_addr  = addr_q;
        sram_wdata = wdata_q;
    end

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: one instance without wait states and
// one with three, each backed by a small behavioural SRAM.
module tb_memory_responder;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        en0 = 0, cmd0 = 0, ready0, valid0, berr0, sen0;
    logic [31:0] addr0 = 0, wd0 = 0, rd0, swd0, srd0;
    logic [3:0]  strb0 = 0, swe0;
    logic [13:0] saddr0;
    logic        en3 = 0, cmd3 = 0, ready3, valid3, berr3, sen3;
    logic [31:0] addr3 = 0, wd3 = 0, rd3, swd3, srd3;
    logic [3:0]  strb3 = 0, swe3;
    logic [13:0] saddr3;

    logic [31:0] mem0 [0:16383];
    logic [31:0] mem3 [0:16383];

    memory_responder #(.ADDR_WIDTH(14), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .memory_enable(en0), .memory_command(cmd0),
        .address(addr0), .write_data(wd0), .write_strobe(strb0), .memory_ready(ready0),
        .memory_valid(valid0), .read_data(rd0), .bus_error(berr0), .sram_en(sen0),
        .sram_we(swe0), .sram_addr(saddr0), .sram_wdata(swd0), .sram_rdata(srd0)
    );

    memory_responder #(.ADDR_WIDTH(14), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .memory_enable(en3), .memory_command(cmd3),
        .address(addr3), .write_data(wd3), .write_strobe(strb3), .memory_ready(ready3),
        .memory_valid(valid3), .read_data(rd3), .bus_error(berr3), .sram_en(sen3),
        .sram_we(swe3), .sram_addr(saddr3), .sram_wdata(swd3), .sram_rdata(srd3)
    );

    always @(posedge clk) begin
        if (sen0) begin
            for (int i = 0; i < 4; i++) if (swe0[i]) mem0[saddr0][8*i +: 8] <= swd0[8*i +: 8];
            srd0 <= mem0[saddr0];
        end
    end

    always @(posedge clk) begin
        if (sen3) begin
            for (int j = 0; j < 4; j++) if (swe3[j]) mem3[saddr3][8*j +: 8] <= swd3[8*j +: 8];
            srd3 <= mem3[saddr3];
        end
    end

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (ready0 !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", ready0); end
        tests++; if (valid0 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid0); end
        tests++; if (rd0 !== 32'd0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rd0); end
        tests++; if (sen0 !== 1'b0 || swe0 !== 4'd0) begin
            fails++; $display("FAIL reset_sram: en %b we %b want 0/0", sen0, swe0); end
        tests++; if (berr0 !== 1'b0) begin fails++; $display("FAIL reset_berr: got %b want 0", berr0); end
        reset_n = 1'b1;
        #1;
        tests++; if (ready0 !== 1'b0) begin fails++; $display("FAIL release_ready_early: got %b want 0", ready0); end
        @(posedge clk); #1;
        tests++; if (ready0 !== 1'b1 || ready3 !== 1'b1) begin
            fails++; $display("FAIL release_ready: got %b/%b want 1/1", ready0, ready3); end
    endtask

    task automatic test_read;
        en0 = 1; cmd0 = 0; addr0 = 32'h0000_0010;
        @(posedge clk); #1;
        en0 = 0; addr0 = 32'hFFFF_FFFF;
        tests++; if (sen0 !== 1'b1 || saddr0 !== 14'd4 || swe0 !== 4'd0) begin
            fails++; $display("FAIL read_access: en %b addr %0d we %b want 1/4/0", sen0, saddr0, swe0); end
        tests++; if (ready0 !== 1'b0 || valid0 !== 1'b0) begin
            fails++; $display("FAIL read_access_hs: ready %b valid %b want 0/0", ready0, valid0); end
        @(posedge clk); #1;
        tests++; if (valid0 !== 1'b1 || ready0 !== 1'b0 || berr0 !== 1'b0) begin
            fails++; $display("FAIL read_resp_hs: valid %b ready %b berr %b want 1/0/0", valid0, ready0, berr0); end
        tests++; if (rd0 !== 32'hDEAD_BEEF) begin fails++; $display("FAIL read_data: got %h want deadbeef", rd0); end
        @(posedge clk); #1;
        tests++; if (valid0 !== 1'b0 || ready0 !== 1'b1 || rd0 !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL read_hold: valid %b ready %b data %h want 0/1/deadbeef", valid0, ready0, rd0); end
    endtask

    task automatic test_write;
        en0 = 1; cmd0 = 1; addr0 = 32'h0000_0008; wd0 = 32'h1122_3344; strb0 = 4'b0011;
        @(posedge clk); #1;
        en0 = 0; wd0 = 0; strb0 = 0;
        tests++; if (sen0 !== 1'b1 || swe0 !== 4'b0011 || saddr0 !== 14'd2 || swd0 !== 32'h1122_3344) begin
            fails++; $display("FAIL write_access: en %b we %b addr %0d wd %h want 1/0011/2/11223344",
                              sen0, swe0, saddr0, swd0); end
        @(posedge clk); #1;
        tests++; if (valid0 !== 1'b1 || rd0 !== 32'd0 || berr0 !== 1'b0) begin
            fails++; $display("FAIL write_resp: valid %b data %h berr %b want 1/0/0", valid0, rd0, berr0); end
        @(posedge clk); #1;
        en0 = 1; cmd0 = 0; addr0 = 32'h0000_0008;
        @(posedge clk); #1;
        en0 = 0;
        @(posedge clk); #1;
        tests++; if (valid0 !== 1'b1 || rd0 !== 32'hAAAA_3344) begin
            fails++; $display("FAIL write_readback: valid %b data %h want 1/aaaa3344", valid0, rd0); end
        @(posedge clk); #1;
        en0 = 1; cmd0 = 1; addr0 = 32'h0000_0010; wd0 = 32'h5555_5555; strb0 = 4'b0000;
        @(posedge clk); #1;
        en0 = 0;
        tests++; if (sen0 !== 1'b1 || swe0 !== 4'b0000) begin
            fails++; $display("FAIL zero_strobe_access: en %b we %b want 1/0000", sen0, swe0); end
        @(posedge clk); #1;
        tests++; if (valid0 !== 1'b1 || berr0 !== 1'b0 || rd0 !== 32'd0) begin
            fails++; $display("FAIL zero_strobe_resp: valid %b berr %b data %h want 1/0/0", valid0, berr0, rd0); end
        @(posedge clk); #1;
    endtask

    task automatic test_bus_error;
        en0 = 1; cmd0 = 0; addr0 = 32'h0001_0000;
        @(posedge clk); #1;
        en0 = 0;
        tests++; if (valid0 !== 1'b1 || berr0 !== 1'b1 || rd0 !== 32'd0 || sen0 !== 1'b0) begin
            fails++; $display("FAIL bus_error_resp: valid %b berr %b data %h en %b want 1/1/0/0",
                              valid0, berr0, rd0, sen0); end
        @(posedge clk); #1;
        tests++; if (berr0 !== 1'b0 || valid0 !== 1'b0 || ready0 !== 1'b1) begin
            fails++; $display("FAIL bus_error_after: berr %b valid %b ready %b want 0/0/1", berr0, valid0, ready0); end
    endtask

    task automatic test_back_to_back;
        int pulses = 0, overlap = 0, first = 0, bad_gap = 0, last = 0;
        en0 = 1; cmd0 = 0; addr0 = 32'h0000_0010;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            if (ready0 && valid0) overlap++;
            if (valid0) begin
                if (pulses == 0) first = c;
                else if (c - last != 3) bad_gap++;
                last = c;
                pulses++;
            end
        end
        en0 = 0;
        tests++; if (pulses != 3 || first != 2 || bad_gap != 0) begin
            fails++; $display("FAIL b2b_spacing: pulses %0d first %0d badgaps %0d want 3/2/0", pulses, first, bad_gap); end
        tests++; if (overlap != 0) begin fails++; $display("FAIL b2b_ready_valid: overlaps %0d want 0", overlap); end
        @(posedge clk); #1;
    endtask

    task automatic test_wait_states;
        en3 = 1; cmd3 = 0; addr3 = 32'h0000_0014;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            tests++; if (ready3 !== (k >= 6) || valid3 !== (k == 5) || sen3 !== (k == 4)) begin
                fails++; $display("FAIL wait_cycle%0d: ready %b valid %b en %b want %b/%b/%b",
                                  k, ready3, valid3, sen3, k >= 6, k == 5, k == 4); end
            if (k == 4) begin
                tests++; if (saddr3 !== 14'd5) begin fails++; $display("FAIL wait_addr: got %0d want 5", saddr3); end
            end
            if (k == 5) begin
                tests++; if (rd3 !== 32'hCAFE_F00D) begin fails++; $display("FAIL wait_data: got %h want cafef00d", rd3); end
                en3 = 0;
            end
        end
    endtask

    task automatic test_reset_mid_wait;
        int spurious = 0, lat = 0;
        en3 = 1; cmd3 = 0; addr3 = 32'h0000_0014;
        @(posedge clk); #1;
        en3 = 0; en0 = 1; cmd0 = 0; addr0 = 32'h0000_0010;
        @(posedge clk); #1;
        en0 = 0;
        tests++; if (sen0 !== 1'b1) begin fails++; $display("FAIL abort_setup: en %b want 1", sen0); end
        #2 reset_n = 1'b0;
        #1;
        tests++; if (sen0 !== 1'b0 || ready0 !== 1'b0 || ready3 !== 1'b0 || sen3 !== 1'b0) begin
            fails++; $display("FAIL abort_immediate: en0 %b rdy0 %b rdy3 %b en3 %b want 0/0/0/0",
                              sen0, ready0, ready3, sen3); end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (valid0 || valid3) spurious++;
            if (c == 2) reset_n = 1'b1;
        end
        tests++; if (spurious != 0) begin fails++; $display("FAIL abort_no_valid: pulses %0d want 0", spurious); end
        en3 = 1; addr3 = 32'h0000_0010;
        @(posedge clk); #1;
        en3 = 0;
        lat = 1;
        while (!valid3 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++; if (valid3 !== 1'b1 || lat != 5 || rd3 !== 32'h1234_5678) begin
            fails++; $display("FAIL post_reset_read: valid %b latency %0d data %h want 1/5/12345678",
                              valid3, lat, rd3); end
        @(posedge clk); #1;
    endtask

    initial begin
        mem0[2] = 32'hAAAA_AAAA;
        mem0[4] = 32'hDEAD_BEEF;
        mem3[4] = 32'h1234_5678;
        mem3[5] = 32'hCAFE_F00D;
        test_reset();
        test_read();
        test_write();
        test_bus_error();
        test_back_to_back();
        test_wait_states();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/memory_responder.md
Name: memory_responder

Overview:
- Slave end of the core's memory handshake: accepts requests presented as memory_enable/memory_command while memory_ready is high, performs them on an external synchronous single-port SRAM, and returns completion as a one-cycle memory_valid pulse.
- Serves both instruction fetch and load/store traffic from the multi-cycle controller/datapath.
- Adds configurable wait states and out-of-range bus-error detection.

Parameters:
- ADDR_WIDTH, 14, SRAM word-address width (SRAM holds 2^ADDR_WIDTH 32-bit words).
- WAIT_STATES, 0, extra idle cycles inserted between request acceptance and SRAM access (0..15).

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- memory_enable  input  1  request strobe; sampled only while memory_ready=1
- memory_command  input  1  0=read, 1=write
- address  input  32  byte address; bits [1:0] ignored (word access)
- write_data  input  32  store data, already lane-aligned
- write_strobe  input  4  byte-lane write enables for writes
- memory_ready  output  1  responder idle, request may be issued
- memory_valid  output  1  one-cycle completion pulse
- read_data  output  32  read result
- bus_error  output  1  qualifies memory_valid: access was out of range
- sram_en  output  1  SRAM access strobe
- sram_we  output  4  SRAM byte write enables
- sram_addr  output  ADDR_WIDTH  SRAM word address
- sram_wdata  output  32  SRAM write data
- sram_rdata  input  32  SRAM read data, valid the cycle after sram_en with sram_we=0

Behaviour:
Clock and reset:
- One clock, clk. reset_n is asynchronous and active-low.
- While reset_n=0: state=IDLE; memory_ready=0, memory_valid=0, bus_error=0, read_data=0, sram_en=0, sram_we=0.
- memory_ready is registered and rises on the first clk edge after reset_n deasserts.

States:
- IDLE: memory_ready=1. memory_enable=1 accepts the request: address, command, write_data and write_strobe are latched.
  - Out of range (address[31:ADDR_WIDTH+2] != 0) -> RESPOND with err.
  - WAIT_STATES=0 -> ACCESS.
  - Otherwise -> WAIT, with the counter loaded to WAIT_STATES-1.
- WAIT: memory_ready=0. Counter decrements each cycle; -> ACCESS when it reaches 0.
- ACCESS: memory_ready=0.
  - Drives sram_en=1 and sram_addr=latched address[ADDR_WIDTH+1:2].
  - Write: sram_we=latched strobe and sram_wdata=latched data.
  - Read: sram_we=0.
  - -> RESPOND.
- RESPOND: memory_valid=1, memory_ready=0.
  - Read: read_data=sram_rdata (combinational pass-through this cycle), also captured into the holding register.
  - Error: read_data=0, bus_error=1.
  - -> IDLE.

Latency:
- Request accepted at edge T -> memory_valid high during cycle T+2+WAIT_STATES. Bus errors complete in cycle T+1.

Handshake rules:
- memory_ready and memory_valid are never high in the same cycle. This prevents a requester that holds enable across completion from issuing a second request.
- memory_enable outside IDLE is ignored.
- Inputs are latched, so the requester may change them after acceptance.

Hold and edge cases:
- read_data holds its last value outside RESPOND; it is 0 after a write or error completion. bus_error is 0 except in error RESPOND.
- write_strobe=0000: SRAM access still issued with sram_we=0 (a harmless read), then a normal valid, no error.
- Reset mid-transaction: immediate abort to IDLE. No valid is produced and SRAM strobes drop asynchronously.

Decomposition:
- Package memory_responder_pkg:
  - state enum {IDLE, WAIT, ACCESS, RESPOND};
  - MEM_READ=1'b0 and MEM_WRITE=1'b1 (shared with the controller's memory_command encoding).
- Sub-module wait_state_counter (load, decrement, zero flag, width 4), instantiated only when WAIT_STATES>0.

Test Plan:
- Reset release, WAIT_STATES=0 -> memory_ready 0 during reset, 1 one cycle after. Read 0x00000010 with SRAM word 4=0xDEADBEEF -> sram_en at T+1 with sram_addr=4, valid at T+2 with read_data=0xDEADBEEF, ready low that cycle.
- Write 0x00000008, data 0x11223344, strobe 0011 -> sram_we=0011 and sram_addr=2 in ACCESS. Readback returns 0xAAAA3344 if the word was previously 0xAAAAAAAA.
- WAIT_STATES=3, read -> valid exactly 5 cycles after acceptance; ready low for 5 cycles; enable held high throughout accepts nothing extra.
- Address 0x00010000 with ADDR_WIDTH=14 -> no sram_en, valid at T+1 with bus_error=1 and read_data=0.
- memory_enable held high continuously -> back-to-back requests spaced 3 cycles (WAIT_STATES=0); never ready&valid together.
- reset_n dropped during WAIT -> ready=0 and sram_en=0 immediately, no valid pulse; after release, the next read completes normally.
